// File: rtl/weighted_random_select_n.sv
// Weighted segment selector: LFSR-weighted random pick or weighted round-robin pick per request.
// Latency: random mode 4 + index (+1 per LFSR reject) cycles; round-robin 2 (+1 per zero-weight skip).
// Backpressure: choice held stable in PRESENT while in_ready=0; LFSR frozen until it is accepted.
module weighted_random_select_n #(
    parameter int NUM_SEG  = 4,
    parameter int WEIGHT_W = 11,
    parameter int SEL_W    = $clog2(NUM_SEG),
    parameter int TOTAL_W  = WEIGHT_W + $clog2(NUM_SEG)
) (
    input  logic                        in_clock,
    input  logic                        in_reset,
    input  logic                        in_enable,
    input  logic                        in_mode,
    input  logic                        in_weight_load,
    input  logic [NUM_SEG*WEIGHT_W-1:0] in_weights,
    input  logic [15:0]                 in_seed,
    input  logic                        in_ready,
    output logic                        out_valid,
    output logic [SEL_W-1:0]            out_segment_number,
    output logic                        out_busy,
    output logic                        out_error
);

    typedef enum logic [2:0] {S_IDLE, S_DRAW, S_SAMPLE, S_SCAN, S_PRESENT} state_t;

    state_t              state, state_nxt;
    logic [WEIGHT_W-1:0] shadow_w [NUM_SEG];
    logic [WEIGHT_W-1:0] active_w [NUM_SEG];
    logic [TOTAL_W-1:0]  total_q, acc_q, r_q;
    logic [15:0]         lfsr_q;
    logic [SEL_W-1:0]    idx_q, rr_idx_q;
    logic [WEIGHT_W-1:0] rr_cnt_q;
    logic                mode_q;
    logic                rr_dirty_q;   // weights changed since last draw: restart round-robin

    logic [TOTAL_W-1:0]  shadow_sum, total_m1, mask, sample_r, scan_lim;
    logic [15:0]         lfsr_step;
    logic                shadow_diff;
    logic [SEL_W-1:0]    rr_start, pick_idx;
    logic [WEIGHT_W-1:0] rr_cnt_start, pick_cnt, pick_cnt_inc, pick_w;
    logic                pick_done;

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v);
        return (v == SEL_W'(NUM_SEG - 1)) ? '0 : v + SEL_W'(1);
    endfunction

    assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign sample_r  = lfsr_q[TOTAL_W-1:0] & mask;
    assign scan_lim  = acc_q + TOTAL_W'(active_w[idx_q]);
    assign rr_start     = rr_dirty_q ? '0 : rr_idx_q;
    assign rr_cnt_start = rr_dirty_q ? '0 : rr_cnt_q;
    assign out_valid = (state == S_PRESENT);
    assign out_busy  = (state != S_IDLE);

    // Shadow weight total and change detection against the incoming load
    always_comb begin
        shadow_sum  = '0;
        shadow_diff = 1'b0;
        for (int i = 0; i < NUM_SEG; i++) begin
            shadow_sum = shadow_sum + TOTAL_W'(shadow_w[i]);
            if (in_weights[i*WEIGHT_W +: WEIGHT_W] != shadow_w[i]) shadow_diff = 1'b1;
        end
    end

    // Sample mask: all ones up to the MSB of (total-1), i.e. 2^ceil(log2(total))-1
    always_comb begin
        total_m1 = total_q - TOTAL_W'(1);
        mask     = '0;
        for (int i = 0; i < TOTAL_W; i++) mask[i] = ((total_m1 >> i) != '0);
    end

    // Round-robin candidate: DRAW looks at the shadow weights it is about to copy, SCAN at the active copy
    always_comb begin
        if (state == S_DRAW) begin
            pick_idx = rr_start;
            pick_cnt = rr_cnt_start;
            pick_w   = shadow_w[rr_start];
        end else begin
            pick_idx = rr_idx_q;
            pick_cnt = rr_cnt_q;
            pick_w   = active_w[rr_idx_q];
        end
        pick_cnt_inc = pick_cnt + WEIGHT_W'(1);
        pick_done    = (pick_cnt_inc >= pick_w);
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (in_enable) state_nxt = S_DRAW;
            S_DRAW: begin
                if (shadow_sum == '0)  state_nxt = S_IDLE;
                else if (!in_mode)     state_nxt = S_SAMPLE;
                else if (pick_w == '0) state_nxt = S_SCAN;
                else                   state_nxt = S_PRESENT;
            end
            S_SAMPLE:  if (sample_r < total_q) state_nxt = S_SCAN;
            S_SCAN: begin
                if (mode_q ? (pick_w != '0) : (r_q < scan_lim)) state_nxt = S_PRESENT;
            end
            S_PRESENT: if (in_ready) state_nxt = in_enable ? S_DRAW : S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // State register and datapath
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state              <= S_IDLE;
            lfsr_q             <= (in_seed == 16'd0) ? 16'd1 : in_seed;
            for (int i = 0; i < NUM_SEG; i++) begin
                shadow_w[i] <= '0;
                active_w[i] <= '0;
            end
            total_q            <= '0;
            acc_q              <= '0;
            r_q                <= '0;
            idx_q              <= '0;
            rr_idx_q           <= '0;
            rr_cnt_q           <= '0;
            mode_q             <= 1'b0;
            rr_dirty_q         <= 1'b0;
            out_segment_number <= '0;
            out_error          <= 1'b0;
        end else begin
            state <= state_nxt;
            if (in_weight_load) begin
                for (int i = 0; i < NUM_SEG; i++) shadow_w[i] <= in_weights[i*WEIGHT_W +: WEIGHT_W];
            end
            if (in_weight_load && shadow_diff) rr_dirty_q <= 1'b1;
            else if (state == S_DRAW)          rr_dirty_q <= 1'b0;

            case (state)
                S_DRAW: begin
                    for (int i = 0; i < NUM_SEG; i++) active_w[i] <= shadow_w[i];
                    total_q   <= shadow_sum;
                    lfsr_q    <= lfsr_step;
                    idx_q     <= '0;
                    acc_q     <= '0;
                    mode_q    <= in_mode;
                    out_error <= (shadow_sum == '0);
                    rr_idx_q  <= rr_start;
                    rr_cnt_q  <= rr_cnt_start;
                    if (in_mode && shadow_sum != '0) begin
                        if (pick_w != '0) begin
                            out_segment_number <= pick_idx;
                            rr_cnt_q <= pick_done ? '0 : pick_cnt_inc;
                            rr_idx_q <= pick_done ? wrap_inc(pick_idx) : pick_idx;
                        end else begin
                            rr_idx_q <= wrap_inc(rr_start);
                            rr_cnt_q <= '0;
                        end
                    end
                end
                S_SAMPLE: begin
                    if (sample_r < total_q) r_q <= sample_r;
                    else                    lfsr_q <= lfsr_step;
                end
                S_SCAN: begin
                    if (mode_q) begin
                        if (pick_w != '0) begin
                            out_segment_number <= pick_idx;
                            rr_cnt_q <= pick_done ? '0 : pick_cnt_inc;
                            rr_idx_q <= pick_done ? wrap_inc(pick_idx) : pick_idx;
                        end else begin
                            rr_idx_q <= wrap_inc(rr_idx_q);
                        end
                    end else if (r_q < scan_lim) begin
                        out_segment_number <= idx_q;
                    end else begin
                        acc_q <= scan_lim;
                        idx_q <= idx_q + SEL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
